fetch_sequencer: RTL and testbench

- Front end of the multi-cycle CPU. Owns the PC, the instruction register (IR) and the fetch/execute state machine.
- Fetches a 32-bit instruction from instruction memory over a req/ack handshake and presents it on `instr` to the instruction-class decoders (data transfer, ALU, branch, ...).
- Consumes the sequencing fields of the selected decoder's control word (PS, NState, En_PC) plus the data-memory busy flag.
- Advances the PC and steps the decoders through one or two execute cycles.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fetch_sequencer_if.sv | 25 ++
 rtl/fetch_sequencer_pc_next_calc.sv | 23 ++
 rtl/fetch_sequencer.sv | 89 ++++++++
 tb/tb_fetch_sequencer.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the CPU front end
package cpu_pkg;

  typedef enum logic [1:0] {
    PS_HOLD = 2'b00,
    PS_INC  = 2'b01,
    PS_REG  = 2'b10,
    PS_BR   = 2'b11
  } ps_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC0 = 2'b01,
    ST_EXEC1 = 2'b10,
    ST_BAD   = 2'b11
  } state_e;

  localparam logic [63:0] PC_STEP = 64'd4;

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction fetch bus plus decoder control-word link
interface fetch_sequencer_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        cw_valid;
  logic        exec_phase;
  logic [1:0]  ps;
  logic        nstate;
  logic [63:0] pc_in;
  logic [63:0] br_off;
  logic        mem_busy;

  modport master (
    output imem_req, imem_addr, instr, cw_valid, exec_phase,
    input  imem_ack, imem_rdata, ps, nstate, pc_in, br_off, mem_busy
  );

  modport slave (
    input  imem_req, imem_addr, instr, cw_valid, exec_phase,
    output imem_ack, imem_rdata, ps, nstate, pc_in, br_off, mem_busy
  );
endinterface

// File: rtl/fetch_sequencer_pc_next_calc.sv
// rtl/fetch_sequencer_pc_next_calc.sv - combinational next-PC select, modulo 2^64
module pc_next_calc
  import cpu_pkg::*;
(
  input  ps_e         ps,
  input  logic [63:0] pc,
  input  logic [63:0] pc_in,
  input  logic [63:0] br_off,
  output logic [63:0] next_pc
);

  always_comb begin
    next_pc = pc;
    case (ps)
      PS_HOLD: next_pc = pc;
      PS_INC:  next_pc = pc + PC_STEP;
      PS_REG:  next_pc = pc_in;
      PS_BR:   next_pc = pc + {br_off[61:0], 2'b00};
      default: next_pc = pc;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC, IR and fetch/execute sequencing for the multi-cycle CPU
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  fetch_sequencer_if.master bus,
  output logic [63:0]      pc,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [63:0]      pc_q, pc_d, next_pc;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             started_q, started_d;

  pc_next_calc u_pc_next_calc (
    .ps      (ps_e'(bus.ps)),
    .pc      (pc_q),
    .pc_in   (bus.pc_in),
    .br_off  (bus.br_off),
    .next_pc (next_pc)
  );

  // started_q keeps imem_req low for the first cycle after reset release
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0;
      retired_q <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      started_q <= started_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    started_d = 1'b1;
    case (state_q)
      ST_FETCH: begin
        if (started_q && bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          state_d = ST_EXEC0;
        end
      end
      ST_EXEC0: begin
        if (!bus.mem_busy) begin
          pc_d = next_pc;
          if (bus.nstate) begin
            state_d = ST_EXEC1;
          end else begin
            state_d   = ST_FETCH;
            retired_d = retired_q + CNT_W'(1);
          end
        end
      end
      ST_EXEC1: begin
        if (!bus.mem_busy) begin
          pc_d      = next_pc;
          state_d   = ST_FETCH;
          retired_d = retired_q + CNT_W'(1);
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  assign bus.imem_req   = started_q && (state_q == ST_FETCH);
  assign bus.imem_addr  = pc_q;
  assign bus.instr      = ir_q;
  assign bus.cw_valid   = (state_q == ST_EXEC0) || (state_q == ST_EXEC1);
  assign bus.exec_phase = (state_q == ST_EXEC1);
  assign pc             = pc_q;
  assign retired        = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed-vector bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clock;
  logic        reset_n;
  logic [63:0] pc;
  logic [31:0] retired;
  int          n_vec;
  int          n_bad;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(64'h0), .CNT_W(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .pc      (pc),
    .retired (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // single-cycle acknowledged fetch; leaves the sequencer in EXEC0
  task automatic do_fetch(input logic [31:0] word);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    tick();
    bus.imem_ack   = 1'b0;
    check_vec("fetch_to_exec0", {62'h0, bus.cw_valid, bus.exec_phase}, 64'h2);
    check_vec("ir_load", {32'h0, bus.instr}, {32'h0, word});
  endtask

  task automatic exec_one(input logic [1:0] ps, input logic [63:0] pc_in,
                          input logic [63:0] br_off, input logic [63:0] exp_pc);
    bus.ps = ps; bus.nstate = 1'b0; bus.pc_in = pc_in; bus.br_off = br_off;
    tick();
    check_vec("exec_pc", pc, exp_pc);
    check_vec("exec_back_fetch", {63'h0, bus.imem_req}, 64'h1);
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    reset_n = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.ps = 2'b00; bus.nstate = 1'b0;
    bus.pc_in = 64'h0; bus.br_off = 64'h0; bus.mem_busy = 1'b0;
    #12;
    check_vec("rst_pc", pc, 64'h0);
    check_vec("rst_instr", {32'h0, bus.instr}, 64'h0);
    check_vec("rst_retired", {32'h0, retired}, 64'h0);
    check_vec("rst_req", {63'h0, bus.imem_req}, 64'h0);
    check_vec("rst_cw", {62'h0, bus.cw_valid, bus.exec_phase}, 64'h0);
    reset_n = 1'b1;
    #1;
    check_vec("req_low_after_release", {63'h0, bus.imem_req}, 64'h0);
    tick();
    check_vec("req_first_rise", {63'h0, bus.imem_req}, 64'h1);

    // ack withheld for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check_vec("wait_req", {63'h0, bus.imem_req}, 64'h1);
      check_vec("wait_addr", bus.imem_addr, 64'h0);
      check_vec("wait_cw", {63'h0, bus.cw_valid}, 64'h0);
      check_vec("wait_retired", {32'h0, retired}, 64'h0);
    end

    do_fetch(32'hF84083E1);
    check_vec("exec0_req", {63'h0, bus.imem_req}, 64'h0);
    bus.ps = 2'b01; bus.nstate = 1'b0;
    tick();
    check_vec("t1_pc", pc, 64'h4);
    check_vec("t1_retired", {32'h0, retired}, 64'h1);
    check_vec("t1_req", {63'h0, bus.imem_req}, 64'h1);
    check_vec("t1_addr", bus.imem_addr, 64'h4);
    check_vec("t1_cw", {63'h0, bus.cw_valid}, 64'h0);

    // two-cycle instruction
    do_fetch(32'h12345678);
    bus.ps = 2'b00; bus.nstate = 1'b1;
    tick();
    check_vec("t2_phase1", {62'h0, bus.cw_valid, bus.exec_phase}, 64'h3);
    check_vec("t2_pc_held", pc, 64'h4);
    check_vec("t2_retired_held", {32'h0, retired}, 64'h1);
    check_vec("t2_ir_stable", {32'h0, bus.instr}, 64'h12345678);
    bus.ps = 2'b01; bus.nstate = 1'b1;
    tick();
    check_vec("t2_pc", pc, 64'h8);
    check_vec("t2_retired", {32'h0, retired}, 64'h2);
    check_vec("t2_fetch", {62'h0, bus.imem_req, bus.cw_valid}, 64'h2);

    // data-memory stall in EXEC0
    do_fetch(32'hCAFEF00D);
    bus.ps = 2'b01; bus.nstate = 1'b0; bus.mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_vec("stall_cw", {62'h0, bus.cw_valid, bus.exec_phase}, 64'h2);
      check_vec("stall_pc", pc, 64'h8);
      check_vec("stall_retired", {32'h0, retired}, 64'h2);
    end
    bus.mem_busy = 1'b0;
    tick();
    check_vec("stall_release_pc", pc, 64'hC);
    check_vec("stall_release_retired", {32'h0, retired}, 64'h3);

    // branches and wrap
    do_fetch(32'h1); exec_one(2'b10, 64'h100, 64'h0, 64'h100);
    do_fetch(32'h2); exec_one(2'b11, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 64'hF8);
    do_fetch(32'h3); exec_one(2'b11, 64'h0, 64'h2, 64'h100);
    do_fetch(32'h4); exec_one(2'b10, 64'h2000, 64'h0, 64'h2000);
    do_fetch(32'h5); exec_one(2'b00, 64'h0, 64'h0, 64'h2000);
    do_fetch(32'h6); exec_one(2'b10, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
    do_fetch(32'h7); exec_one(2'b01, 64'h0, 64'h0, 64'h0);
    check_vec("branch_retired", {32'h0, retired}, 64'hA);

    // asynchronous reset mid-EXEC1 with a stray ack
    do_fetch(32'hDEADBEEF);
    bus.ps = 2'b01; bus.nstate = 1'b1;
    tick();
    check_vec("pre_rst_exec1", {62'h0, bus.cw_valid, bus.exec_phase}, 64'h3);
    bus.pc_in = 64'h5555; bus.ps = 2'b10;
    #2;
    reset_n = 1'b0;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBADBAD00;
    #1;
    check_vec("async_pc", pc, 64'h0);
    check_vec("async_instr", {32'h0, bus.instr}, 64'h0);
    check_vec("async_retired", {32'h0, retired}, 64'h0);
    check_vec("async_cw", {61'h0, bus.imem_req, bus.cw_valid, bus.exec_phase}, 64'h0);
    tick();
    check_vec("held_rst_instr", {32'h0, bus.instr}, 64'h0);
    #2;
    reset_n = 1'b1;
    tick();
    check_vec("stray_ack_ignored", {32'h0, bus.instr}, 64'h0);
    check_vec("stray_ack_state", {62'h0, bus.cw_valid, bus.imem_req}, 64'h1);
    check_vec("restart_addr", bus.imem_addr, 64'h0);
    bus.imem_ack = 1'b0;
    do_fetch(32'h0BADF00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
